mod_multiplier: RTL and testbench

- Inverse of the pipelined restoring divider: reconstructs dividend = merchant * divisor + remainder.
- Sequential shift-add engine, one merchant bit per cycle.
- Used as a round-trip checker behind the divider and as the multiply path of the arithmetic datapath.
- Valid/ready on both sides. Also flags tuples that no legal division could have produced.

---
 rtl/mod_div_pkg.sv | 16 +
 rtl/mod_multiplier_step.sv | 18 +
 rtl/mod_multiplier.sv | 96 +++++++++
 tb/tb_mod_multiplier.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_div_pkg.sv
// Shared widths and state encoding for the restoring divider and its inverse multiplier.
// Both blocks import this so operand widths can never drift apart.
package mod_div_pkg;

   localparam int DIVIDEND_W = 26;
   localparam int DIVISOR_W  = 14;
   localparam int PRODUCT_W  = DIVIDEND_W + DIVISOR_W;
   localparam int COUNT_W    = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/mod_multiplier_step.sv
// One shift-add iteration: conditionally adds the shifted multiplicand, then advances
// the multiplicand left and the multiplier right by one bit.
module mod_multiplier_step
   import mod_div_pkg::*;
(
   input  logic [PRODUCT_W-1:0]  acc_i,
   input  logic [PRODUCT_W-1:0]  mcand_i,
   input  logic [DIVIDEND_W-1:0] mplier_i,
   output logic [PRODUCT_W-1:0]  acc_o,
   output logic [PRODUCT_W-1:0]  mcand_o,
   output logic [DIVIDEND_W-1:0] mplier_o
);

   assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
   assign mcand_o  = mcand_i << 1;
   assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/mod_multiplier.sv
// Reconstructs dividend = merchant * divisor + remainder with a fixed-latency shift-add
// engine, and flags operand tuples that no legal division could have produced.
module mod_multiplier
   import mod_div_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] merchant,
   input  logic [DIVISOR_W-1:0]  divisor,
   input  logic [DIVISOR_W-1:0]  remainder,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PRODUCT_W-1:0]  product,
   output logic                  tuple_err
);

   localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(DIVIDEND_W - 1);

   state_e                  state_q;
   logic [PRODUCT_W-1:0]    acc_q;
   logic [PRODUCT_W-1:0]    mcand_q;
   logic [DIVIDEND_W-1:0]   mplier_q;
   logic [COUNT_W-1:0]      count_q;
   logic                    errPend_q;
   logic [PRODUCT_W-1:0]    product_q;
   logic                    tupleErr_q;
   logic                    outValid_q;

   logic [PRODUCT_W-1:0]    acc_d;
   logic [PRODUCT_W-1:0]    mcand_d;
   logic [DIVIDEND_W-1:0]   mplier_d;

   mod_multiplier_step uStep (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (acc_d),
      .mcand_o  (mcand_d),
      .mplier_o (mplier_d)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = outValid_q;
   assign product   = product_q;
   assign tuple_err = tupleErr_q;

   // The remainder seeds the accumulator so the final add-shift pass yields the full dividend.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         count_q    <= '0;
         errPend_q  <= 1'b0;
         product_q  <= '0;
         tupleErr_q <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  acc_q     <= {{(PRODUCT_W-DIVISOR_W){1'b0}}, remainder};
                  mcand_q   <= {{(PRODUCT_W-DIVISOR_W){1'b0}}, divisor};
                  mplier_q  <= merchant;
                  count_q   <= '0;
                  errPend_q <= (divisor == '0) || (remainder >= divisor);
                  state_q   <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               count_q  <= count_q + COUNT_W'(1);
               if (count_q == LAST_COUNT) begin
                  product_q  <= acc_d;
                  tupleErr_q <= errPend_q;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_multiplier.sv
// Self-checking bench for mod_multiplier: table vectors, latency, backpressure,
// mid-operation reset and a divide/multiply round-trip through a scoreboard.
module tb_mod_multiplier;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] merchant;
   logic [13:0] divisor;
   logic [13:0] remainder;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] product;
   logic        tuple_err;

   int assertCount;
   int failCount;

   logic [39:0] expProductQ[$];
   logic        expErrQ[$];
   logic [39:0] pendProduct;
   logic        pendErr;

   typedef struct {
      logic [25:0] m;
      logic [13:0] d;
      logic [13:0] r;
      logic [39:0] expP;
      logic        expE;
   } vector_t;

   vector_t vectors[6];

   mod_multiplier dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .merchant  (merchant),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .tuple_err (tuple_err)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so a stuck handshake can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard: record expectations on accept, compare on each output handshake.
   always @(negedge clk) begin
      if (rst) begin
         expProductQ.delete();
         expErrQ.delete();
      end else begin
         if (in_valid && in_ready) begin
            expProductQ.push_back(pendProduct);
            expErrQ.push_back(pendErr);
         end
         if (out_valid && out_ready) begin
            if (expProductQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpected_output: got product 0x%0h, expected no output", product);
            end else begin
               checkOutput("product", product, expProductQ.pop_front());
               checkOutput("tuple_err", {39'b0, tuple_err}, {39'b0, expErrQ.pop_front()});
            end
         end
      end
   end

   // Drives a tuple until it is accepted; returns #1 after the accepting edge with in_valid low.
   task automatic applyStimulus(input logic [25:0] m, input logic [13:0] d, input logic [13:0] r,
                                input logic [39:0] expP, input logic expE);
      bit taken;
      taken = 0;
      @(posedge clk);
      #1;
      merchant    = m;
      divisor     = d;
      remainder   = r;
      pendProduct = expP;
      pendErr     = expE;
      in_valid    = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (in_ready) begin
            taken = 1;
            break;
         end
      end
      if (!taken) checkOutput("accept_timeout", 40'd0, 40'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitDone();
      bit got;
      got = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) checkOutput("output_timeout", 40'd0, 40'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int firstHigh;
      logic [25:0] dividend;
      logic [13:0] dv;

      assertCount = 0;
      failCount   = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      merchant    = '0;
      divisor     = '0;
      remainder   = '0;
      pendProduct = '0;
      pendErr     = 1'b0;

      vectors[0] = '{26'd5,        14'd3,      14'd2,      40'd17,           1'b0};
      vectors[1] = '{26'h3FFFFFF,  14'h3FFF,   14'h3FFE,   40'hFFFBFFFFFF,   1'b0};
      vectors[2] = '{26'd123,      14'd0,      14'd7,      40'd7,            1'b1};
      vectors[3] = '{26'd10,       14'd4,      14'd4,      40'd44,           1'b1};
      vectors[4] = '{26'd0,        14'd5,      14'd4,      40'd4,            1'b0};
      vectors[5] = '{26'd1,        14'd1,      14'd0,      40'd1,            1'b0};

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", {39'b0, out_valid}, 40'd0);
      checkOutput("reset_product", product, 40'd0);
      checkOutput("reset_tuple_err", {39'b0, tuple_err}, 40'd0);
      checkOutput("reset_in_ready", {39'b0, in_ready}, 40'd1);

      // Latency: out_valid must be visible at the 27th edge after the accept, not earlier.
      applyStimulus(vectors[0].m, vectors[0].d, vectors[0].r, vectors[0].expP, vectors[0].expE);
      firstHigh = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (out_valid) begin
            firstHigh = k;
            break;
         end
      end
      checkOutput("latency_edges", 40'(firstHigh), 40'd27);
      @(negedge clk);
      checkOutput("post_handshake_out_valid", {39'b0, out_valid}, 40'd0);
      checkOutput("post_handshake_in_ready", {39'b0, in_ready}, 40'd1);

      for (int i = 1; i < 6; i++) begin
         applyStimulus(vectors[i].m, vectors[i].d, vectors[i].r, vectors[i].expP, vectors[i].expE);
         waitDone();
      end

      // Backpressure: result must hold while new operands are offered and ignored.
      out_ready = 1'b0;
      applyStimulus(26'd1000, 14'd77, 14'd5, 40'd77005, 1'b0);
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         in_valid    = 1'b1;
         merchant    = 26'($urandom);
         divisor     = 14'($urandom);
         remainder   = 14'($urandom);
         pendProduct = 40'hDEADBEEF00;
         pendErr     = 1'b1;
         @(negedge clk);
         checkOutput("bp_out_valid", {39'b0, out_valid}, 40'd1);
         checkOutput("bp_product", product, 40'd77005);
         checkOutput("bp_tuple_err", {39'b0, tuple_err}, 40'd0);
         checkOutput("bp_in_ready", {39'b0, in_ready}, 40'd0);
      end
      @(posedge clk);
      #1;
      merchant    = 26'd3;
      divisor     = 14'd5;
      remainder   = 14'd9;
      pendProduct = 40'd24;
      pendErr     = 1'b1;
      out_ready   = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("bp_next_accept_ready", {39'b0, in_ready}, 40'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDone();

      // Reset at RUN count 10 discards the operation entirely.
      applyStimulus(26'd500, 14'd300, 14'd20, 40'd150020, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_out_valid", {39'b0, out_valid}, 40'd0);
      checkOutput("abort_in_ready", {39'b0, in_ready}, 40'd1);
      applyStimulus(26'd7, 14'd9, 14'd8, 40'd71, 1'b0);
      waitDone();

      // Round-trip: divide in the bench, reconstruct in the DUT, expect the original dividend.
      for (int n = 0; n < 1000; n++) begin
         dividend = 26'($urandom);
         dv       = 14'($urandom_range(1, 16383));
         applyStimulus(dividend / 26'(dv), dv, 14'(dividend % 26'(dv)), {14'b0, dividend}, 1'b0);
         waitDone();
      end

      checkOutput("scoreboard_drained", 40'(expProductQ.size()), 40'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
